// File: rtl/pipe_hazard_ctrl.sv
// Hazard and hold sequencer for the 5-stage vector pipeline: EX/MEM/WB write scoreboard,
// RAW detection against ID, multi-cycle memop hold. Define WB_BYPASS_EN to exclude WB from the checked set.
module pipe_hazard_ctrl #(
  parameter int unsigned AW         = 3,
  parameter int unsigned MEM_CYCLES = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          id_valid,
  input  logic [3:0]    id_opcode,
  input  logic          id_rdv,
  input  logic          id_rds,
  input  logic [AW-1:0] id_src_a,
  input  logic [AW-1:0] id_src_b,
  input  logic [AW-1:0] id_src_s,
  input  logic          id_wrv,
  input  logic          id_wrs,
  input  logic [AW-1:0] id_dest,
  output logic          issue,
  output logic          stall,
  output logic          bubble,
  output logic          pipe_hold,
  output logic          mem_busy,
  output logic [15:0]   hz_cnt
);

  localparam int unsigned CW = (MEM_CYCLES < 2) ? 1 : $clog2(MEM_CYCLES);
  localparam logic [CW:0] LAST = (CW+1)'(MEM_CYCLES - 1);

  typedef struct packed {
    logic          valid;
    logic          wv;
    logic          ws;
    logic          memop;
    logic [AW-1:0] dest;
  } entry_t;

  typedef enum logic {IDLE, MEM_WAIT} state_t;

  state_t        state_q, state_d;
  entry_t        ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  logic [CW-1:0] mem_cnt_q, mem_cnt_d;
  logic [15:0]   hz_cnt_q, hz_cnt_d;

  logic          hold_start, hold_raw, hazard, issue_raw, bubble_raw, id_memop;
  logic [CW:0]   cnt_inc;
  entry_t        id_entry;

  function automatic logic entry_hit(input entry_t e, input logic rdv, input logic rds,
                                     input logic [AW-1:0] sa, input logic [AW-1:0] sb,
                                     input logic [AW-1:0] ss);
    return e.valid && ((rdv && e.wv && (e.dest == sa || e.dest == sb)) ||
                       (rds && e.ws && (e.dest == ss)));
  endfunction

  always_comb begin
    id_memop = (id_opcode == 4'b0011) || (id_opcode == 4'b0100) || (id_opcode == 4'b1111);
    id_entry = '{valid: 1'b1, wv: id_wrv, ws: id_wrs, memop: id_memop, dest: id_dest};

    cnt_inc    = {1'b0, mem_cnt_q} + 1'b1;
    hold_start = (state_q == IDLE) && mem_q.valid && mem_q.memop && ({1'b0, mem_cnt_q} < LAST);
    hold_raw   = (state_q == MEM_WAIT) || hold_start;

`ifdef WB_BYPASS_EN
    hazard = id_valid &&
             (entry_hit(ex_q,  id_rdv, id_rds, id_src_a, id_src_b, id_src_s) ||
              entry_hit(mem_q, id_rdv, id_rds, id_src_a, id_src_b, id_src_s));
`else
    hazard = id_valid &&
             (entry_hit(ex_q,  id_rdv, id_rds, id_src_a, id_src_b, id_src_s) ||
              entry_hit(mem_q, id_rdv, id_rds, id_src_a, id_src_b, id_src_s) ||
              entry_hit(wb_q,  id_rdv, id_rds, id_src_a, id_src_b, id_src_s));
`endif

    issue_raw  = id_valid && !hazard && !hold_raw;
    bubble_raw = hazard && !hold_raw;

    ex_d      = ex_q;
    mem_d     = mem_q;
    wb_d      = wb_q;
    mem_cnt_d = '0;
    if (!hold_raw) begin
      wb_d  = mem_q;
      mem_d = ex_q;
      ex_d  = issue_raw ? id_entry : '0;
    end else begin
      mem_cnt_d = cnt_inc[CW-1:0];
    end

    // Leave MEM_WAIT as the count reaches MEM_CYCLES-1, so the following cycle
    // (memop's last in MEM) is unheld and shifts it out.
    state_d = IDLE;
    if (hold_raw && (cnt_inc < LAST)) state_d = MEM_WAIT;

    hz_cnt_d = hz_cnt_q;
    if (bubble_raw && (hz_cnt_q != '1)) hz_cnt_d = hz_cnt_q + 16'd1;

    issue     = !reset && issue_raw;
    stall     = !reset && (hazard || hold_raw);
    bubble    = !reset && bubble_raw;
    pipe_hold = !reset && hold_raw;
    mem_busy  = !reset && hold_raw;
    hz_cnt    = reset ? '0 : hz_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      ex_q      <= '0;
      mem_q     <= '0;
      wb_q      <= '0;
      mem_cnt_q <= '0;
      hz_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      ex_q      <= ex_d;
      mem_q     <= mem_d;
      wb_q      <= wb_d;
      mem_cnt_q <= mem_cnt_d;
      hz_cnt_q  <= hz_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (AW=3, MEM_CYCLES=4); bubble counts follow WB_BYPASS_EN.
module tb_pipe_hazard_ctrl;

`ifdef WB_BYPASS_EN
  localparam int NB = 2;
`else
  localparam int NB = 3;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid, id_rdv, id_rds, id_wrv, id_wrs;
  logic [3:0] id_opcode;
  logic [2:0] id_src_a, id_src_b, id_src_s, id_dest;
  logic       issue, stall, bubble, pipe_hold, mem_busy;
  logic [15:0] hz_cnt;

  int vectors = 0;
  int miscompares = 0;

  // ctrl vector order: {issue, stall, bubble, pipe_hold, mem_busy}
  localparam logic [4:0] C_NONE  = 5'b00000;
  localparam logic [4:0] C_ISSUE = 5'b10000;
  localparam logic [4:0] C_BUB   = 5'b01100;
  localparam logic [4:0] C_HOLD  = 5'b01011;

  pipe_hazard_ctrl #(.AW(3), .MEM_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rdv(id_rdv), .id_rds(id_rds), .id_src_a(id_src_a), .id_src_b(id_src_b),
    .id_src_s(id_src_s), .id_wrv(id_wrv), .id_wrs(id_wrs), .id_dest(id_dest),
    .issue(issue), .stall(stall), .bubble(bubble), .pipe_hold(pipe_hold),
    .mem_busy(mem_busy), .hz_cnt(hz_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [3:0] op, input logic rdv, input logic rds,
                        input logic [2:0] sa, input logic [2:0] sb, input logic [2:0] ss,
                        input logic wrv, input logic wrs, input logic [2:0] dest);
    id_valid = v; id_opcode = op; id_rdv = rdv; id_rds = rds;
    id_src_a = sa; id_src_b = sb; id_src_s = ss;
    id_wrv = wrv; id_wrs = wrs; id_dest = dest;
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ctrl();
    return {11'd0, issue, stall, bubble, pipe_hold, mem_busy};
  endfunction

  task automatic idle_id();
    set_id(1'b0, 4'h0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0);
  endtask

  initial begin
    reset = 1'b1;
    set_id(1'b1, 4'h1, 1'b1, 1'b0, 3'd1, 3'd1, 3'd0, 1'b1, 1'b0, 3'd1);
    chk("reset_ctrl_forced", ctrl(), {11'd0, C_NONE});
    chk("reset_hz_forced", hz_cnt, 16'd0);
    tick();
    tick();
    chk("reset_ctrl_held", ctrl(), {11'd0, C_NONE});
    reset = 1'b0;
    idle_id();
    chk("idle_ctrl", ctrl(), {11'd0, C_NONE});
    chk("idle_hz", hz_cnt, 16'd0);

    // vector RAW on v2
    set_id(1'b1, 4'h1, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b1, 1'b0, 3'd2);
    chk("vwr_issue", ctrl(), {11'd0, C_ISSUE});
    tick();
    set_id(1'b1, 4'h1, 1'b1, 1'b0, 3'd2, 3'd7, 3'd0, 1'b0, 1'b0, 3'd0);
    for (int i = 0; i < NB; i++) begin
      chk($sformatf("raw_bubble_%0d", i), ctrl(), {11'd0, C_BUB});
      tick();
    end
    chk("raw_release_issue", ctrl(), {11'd0, C_ISSUE});
    chk("raw_hz_cnt", hz_cnt, 16'(NB));
    tick();

    // scalar write does not block a vector read of the same number
    set_id(1'b1, 4'h1, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b1, 3'd5);
    chk("swr_issue", ctrl(), {11'd0, C_ISSUE});
    tick();
    set_id(1'b1, 4'h1, 1'b1, 1'b0, 3'd5, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0);
    chk("vread_indep_issue", ctrl(), {11'd0, C_ISSUE});
    tick();
    set_id(1'b1, 4'h1, 1'b0, 1'b1, 3'd0, 3'd0, 3'd5, 1'b0, 1'b0, 3'd0);
    chk("sread_mem_bubble", ctrl(), {11'd0, C_BUB});
    idle_id();
    chk("invalid_no_stall", ctrl(), {11'd0, C_NONE});
    tick(); tick(); tick();
    chk("hz_unchanged", hz_cnt, 16'(NB));

    // 0011 memop: 3 hold cycles with a dependent reader waiting in ID
    set_id(1'b1, 4'b0011, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b1, 1'b0, 3'd3);
    chk("memop_issue", ctrl(), {11'd0, C_ISSUE});
    tick();
    idle_id();
    chk("memop_in_ex_nohold", ctrl(), {11'd0, C_NONE});
    tick();
    set_id(1'b1, 4'h1, 1'b1, 1'b0, 3'd3, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("memop_hold_%0d", i), ctrl(), {11'd0, C_HOLD});
      tick();
    end
    chk("hold_no_hz", hz_cnt, 16'(NB));
    for (int i = 0; i < NB - 1; i++) begin
      chk($sformatf("post_hold_bubble_%0d", i), ctrl(), {11'd0, C_BUB});
      tick();
    end
    chk("post_hold_issue", ctrl(), {11'd0, C_ISSUE});
    chk("post_hold_hz", hz_cnt, 16'(2 * NB - 1));
    idle_id();
    tick(); tick();

    // two back-to-back 0100 memops: hold,hold,hold,free twice
    set_id(1'b1, 4'b0100, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b1, 3'd6);
    tick();
    set_id(1'b1, 4'b0100, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b1, 3'd7);
    chk("memop2_issue", ctrl(), {11'd0, C_ISSUE});
    tick();
    idle_id();
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("b2b_%0d", i), ctrl(), {11'd0, ((i % 4) != 3) ? C_HOLD : C_NONE});
      tick();
    end
    chk("b2b_done", ctrl(), {11'd0, C_NONE});
    tick(); tick();

    // reset while in MEM_WAIT
    set_id(1'b1, 4'b0011, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b1, 1'b0, 3'd4);
    tick();
    idle_id();
    tick();
    tick();
    chk("mid_hold_busy", ctrl(), {11'd0, C_HOLD});
    reset = 1'b1;
    #1;
    chk("mid_hold_reset_forced", ctrl(), {11'd0, C_NONE});
    tick();
    reset = 1'b0;
    set_id(1'b1, 4'h1, 1'b1, 1'b0, 3'd4, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0);
    chk("after_reset_issue", ctrl(), {11'd0, C_ISSUE});
    chk("after_reset_hz", hz_cnt, 16'd0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Pipeline sequencer for the vector processor's 5-stage pipeline (IF, ID, EX, MEM, WB).
- Sits beside the decode-stage control unit and consumes its per-instruction read/write enables.
- Tracks in-flight register writes in a 3-entry scoreboard covering EX, MEM and WB, and detects read-after-write hazards against the instruction in ID.
- Holds the whole pipeline while a multi-cycle vector memory operation occupies MEM, and issues the stall, bubble and hold controls to pipeline registers and PC.

Parameters:
AW, 3, register address width (vector and scalar files share it)
MEM_CYCLES, 4, cycles a vector memory op occupies MEM (≥1)

Ports:
clk  in  1  pipeline clock
reset  in  1  synchronous, active-high reset
id_valid  in  1  ID holds a real instruction
id_opcode  in  4  opcode of ID instruction
id_rdv  in  1  ID reads vector sources
id_rds  in  1  ID reads scalar source
id_src_a  in  AW  vector source A
id_src_b  in  AW  vector source B
id_src_s  in  AW  scalar source
id_wrv  in  1  ID writes vector file at WB
id_wrs  in  1  ID writes scalar file at WB
id_dest  in  AW  destination register
issue  out  1  ID instruction advances to EX this cycle
stall  out  1  freeze PC and IF/ID register
bubble  out  1  load NOP into ID/EX
pipe_hold  out  1  freeze ID/EX, EX/MEM and MEM/WB registers
mem_busy  out  1  FSM in MEM_WAIT
hz_cnt  out  16  saturating count of bubble cycles

Behaviour:
- Reset (clk edge with reset=1): clear all scoreboard entries (valid=0), set mem_cnt=0, FSM=IDLE and hz_cnt=0. While reset=1, all outputs are forced to 0, including issue.
- Scoreboard entry fields: valid, wv, ws, memop, dest.
  - memop=1 for opcodes 4'b0011, 4'b0100 and 4'b1111.
- Entry shift, on each clk edge with pipe_hold=0:
  - MEM→WB, EX→MEM.
  - EX loads the ID fields if issue=1, otherwise an invalid entry (bubble).
- Entry hold: with pipe_hold=1 no entry moves, and EX, MEM and WB keep their contents.
- Hazard detection is combinational. hazard=1 when id_valid=1 and either condition holds for some valid entry in the checked set:
  - vector: id_rdv=1, entry wv=1, and dest equals id_src_a or id_src_b;
  - scalar: id_rds=1, entry ws=1, and dest equals id_src_s.
- Checked set: EX, MEM and WB, subject to the optional feature below.
- Register 0 has no special treatment.
- Output equations:
  - issue = id_valid & ~hazard & ~pipe_hold
  - stall = (id_valid & hazard) | pipe_hold
  - bubble = id_valid & hazard & ~pipe_hold
- FSM:
  - IDLE→MEM_WAIT when the MEM entry is valid with memop=1 and mem_cnt < MEM_CYCLES-1.
  - MEM_WAIT→IDLE on the cycle mem_cnt reaches MEM_CYCLES-1.
  - pipe_hold = mem_busy = (state==MEM_WAIT), or the IDLE→MEM_WAIT condition itself (combinational, same cycle).
- mem_cnt:
  - cleared whenever entries shift;
  - incremented each cycle pipe_hold=1.
  - A memop therefore stays in MEM exactly MEM_CYCLES cycles.
  - MEM_CYCLES=1 never holds.
- Back-to-back memops: the second memop restarts the count after it shifts in.
- Simultaneous hazard and hold: hold wins, so bubble=0 and the hazard is re-evaluated after release.
- hz_cnt increments on each cycle with bubble=1 and saturates at 16'hFFFF.
- Reset mid-hold: the pipeline releases the next cycle and all entries are dropped.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: the register file writes in the first half-cycle, so the WB entry is excluded from the checked set (only EX and MEM are checked).
  - Maximum RAW penalty: 2 bubbles.
- Undefined: EX, MEM and WB are all checked.
  - Maximum RAW penalty: 3 bubbles.

Test Plan:
- After reset, issue vector op (wrv=1, dest=2), then an ID op reading src_a=2 → bubble=1 for 3 cycles (2 with WB_BYPASS_EN), then issue=1; hz_cnt=3 (2).
- Scalar write dest=5, then vector read src_a=5 with rds=0 → no hazard, issue=1 immediately (register files are independent).
- Opcode 0011 issued with MEM_CYCLES=4 → once it enters MEM, pipe_hold=mem_busy=1 for 3 cycles and the entry stays in MEM 4 cycles; the shift resumes on the 4th.
- Two consecutive 0100 ops → two separate 3-cycle holds; no shift happens during either hold.
- Hazard present while pipe_hold=1 → stall=1, bubble=0, issue=0; after release, bubble asserts only if the hazard persists.
- reset=1 during MEM_WAIT → next cycle pipe_hold=0, all entries invalid, and a prior-dependent ID op issues without a bubble.
